// File: rtl/seq_match_logger.sv
// Logs the bit index of every detector match into a small FWFT FIFO, and keeps
// a saturating match count plus a sticky overflow flag.
module seq_match_logger #(
  parameter int IDX_W = 8,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             det,
  input  logic             rd_en,
  output logic [IDX_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic [CNT_W-1:0] match_cnt,
  output logic             overflow,
  output logic [IDX_W-1:0] bit_idx
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             match;
  logic             pop;
  logic             push;

  assign match    = bit_en & det;
  assign rd_valid = (count != '0);
  assign full     = (count == DEPTH_C);
  assign pop      = rd_en & rd_valid;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = match & (~full | pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx   <= '0;
      match_cnt <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (bit_en) bit_idx <= bit_idx + IDX_W'(1);
      if (match && (match_cnt != '1)) match_cnt <= match_cnt + CNT_W'(1);
      if (match && full && !pop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity comes only from the reset pointers and
  // count, so stale words are never visible and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bit_idx;
  end

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed self-checking bench for seq_match_logger (IDX_W=8, CNT_W=8, DEPTH=4).
module tb_seq_match_logger;

  logic       clk = 1'b0;
  logic       rst, bit_en, det, rd_en;
  logic [7:0] rd_data, match_cnt, bit_idx;
  logic       rd_valid, full, overflow;

  int checks = 0;
  int errors = 0;

  seq_match_logger #(.IDX_W(8), .CNT_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .det(det), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .match_cnt(match_cnt), .overflow(overflow), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic be, input logic d, input logic re);
    rst = r; bit_en = be; det = d; rd_en = re;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 1); tick();
      checks++;
      if ({rd_valid, full, overflow, rd_data, match_cnt, bit_idx} !== 27'd0) begin
        errors++;
        $display("FAIL reset_hold%0d: valid=%b full=%b ovf=%b data=%0d cnt=%0d idx=%0d expected all 0",
                 i, rd_valid, full, overflow, rd_data, match_cnt, bit_idx);
      end
    end
    drive(0, 0, 0, 0); tick();
    checks++;
    if ({rd_valid, full, overflow, rd_data, match_cnt, bit_idx} !== 27'd0) begin
      errors++;
      $display("FAIL reset_release: valid=%b full=%b ovf=%b data=%0d cnt=%0d idx=%0d expected all 0",
               rd_valid, full, overflow, rd_data, match_cnt, bit_idx);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, (i == 4) || (i == 10), 0); tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (bit_idx !== 8'd12 || match_cnt !== 8'd2) begin
      errors++;
      $display("FAIL stream_counts: idx=%0d cnt=%0d expected 12 2", bit_idx, match_cnt);
    end
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd4) begin
      errors++;
      $display("FAIL stream_head0: valid=%b data=%0d expected 1 4", rd_valid, rd_data);
    end
    drive(0, 0, 0, 1); tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd10) begin
      errors++;
      $display("FAIL stream_head1: valid=%b data=%0d expected 1 10", rd_valid, rd_data);
    end
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'd0) begin
      errors++;
      $display("FAIL stream_empty: valid=%b data=%0d expected 0 0", rd_valid, rd_data);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 0); tick();
      if (i == 3) begin
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_at4: full=%b ovf=%b expected 1 0", full, overflow);
        end
      end
    end
    drive(0, 0, 0, 0);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b1 || match_cnt !== 8'd6 || bit_idx !== 8'd6) begin
      errors++;
      $display("FAIL ovf_state: full=%b ovf=%b cnt=%0d idx=%0d expected 1 1 6 6",
               full, overflow, match_cnt, bit_idx);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_pop%0d: valid=%b data=%0d expected 1 %0d", i, rd_valid, rd_data, i);
      end
      drive(0, 0, 0, 1); tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (rd_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained: valid=%b full=%b ovf=%b expected 0 0 1", rd_valid, full, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 0); tick();
    end
    drive(0, 1, 1, 1); tick();
    drive(0, 0, 0, 0);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0 || match_cnt !== 8'd5 || rd_data !== 8'd1) begin
      errors++;
      $display("FAIL full_pushpop: full=%b ovf=%b cnt=%0d head=%0d expected 1 0 5 1",
               full, overflow, match_cnt, rd_data);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        errors++;
        $display("FAIL full_drain%0d: valid=%b data=%0d expected 1 %0d", i, rd_valid, rd_data, i);
      end
      drive(0, 0, 0, 1); tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain_end: valid=%b expected 0", rd_valid);
    end
  endtask

  task automatic test_empty_edges();
    do_reset();
    drive(0, 0, 1, 1); tick();
    drive(0, 0, 0, 0);
    checks++;
    if ({rd_valid, full, overflow, match_cnt, bit_idx} !== 19'd0) begin
      errors++;
      $display("FAIL empty_rd_noop: valid=%b full=%b ovf=%b cnt=%0d idx=%0d expected all 0",
               rd_valid, full, overflow, match_cnt, bit_idx);
    end
    drive(0, 1, 1, 1); tick();
    drive(0, 0, 0, 0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd0 || match_cnt !== 8'd1 || bit_idx !== 8'd1) begin
      errors++;
      $display("FAIL empty_push_pop: valid=%b data=%0d cnt=%0d idx=%0d expected 1 0 1 1",
               rd_valid, rd_data, match_cnt, bit_idx);
    end
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    for (int i = 0; i < 257; i++) begin
      drive(0, 1, i >= 255, 0); tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (bit_idx !== 8'd1 || match_cnt !== 8'd2 || rd_data !== 8'd255) begin
      errors++;
      $display("FAIL wrap_head: idx=%0d cnt=%0d head=%0d expected 1 2 255", bit_idx, match_cnt, rd_data);
    end
    drive(0, 0, 0, 1); tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd0) begin
      errors++;
      $display("FAIL wrap_second: valid=%b data=%0d expected 1 0", rd_valid, rd_data);
    end
    tick();
    for (int i = 0; i < 253; i++) begin
      drive(0, 1, 1, 1); tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (match_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_reach: cnt=%0d expected 255", match_cnt);
    end
    drive(0, 1, 1, 1); tick();
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (match_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold: cnt=%0d expected 255", match_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 0); tick();
    end
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || full !== 1'b0 || rd_data !== 8'd1) begin
      errors++;
      $display("FAIL midrst_setup: ovf=%b full=%b head=%0d expected 1 0 1", overflow, full, rd_data);
    end
    drive(1, 1, 1, 0); tick();
    drive(0, 0, 0, 0);
    checks++;
    if ({rd_valid, full, overflow, match_cnt, bit_idx} !== 19'd0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b full=%b ovf=%b cnt=%0d idx=%0d expected all 0",
               rd_valid, full, overflow, match_cnt, bit_idx);
    end
    drive(0, 1, 1, 0); tick();
    drive(0, 0, 0, 0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd0 || match_cnt !== 8'd1 || bit_idx !== 8'd1) begin
      errors++;
      $display("FAIL midrst_first: valid=%b data=%0d cnt=%0d idx=%0d expected 1 0 1 1",
               rd_valid, rd_data, match_cnt, bit_idx);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0);
    test_reset();
    test_stream();
    test_overflow();
    test_full_push_pop();
    test_empty_edges();
    test_wrap_saturate();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_match_logger.md
# seq_match_logger

Downstream consumer of the serial sequence-detector output. It tracks the index of every bit the detector evaluates. It logs the index of each bit that completes a match into a small first-word-fall-through FIFO, and keeps a saturating match counter plus a sticky overflow flag. A host or bench drains the FIFO with a simple read strobe.

## Interface
- IDX_W, 8, width of the bit-index counter and of each logged FIFO entry
- CNT_W, 8, width of the saturating match counter
- DEPTH, 4, number of FIFO entries (power of 2, ≥2)

- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- bit_en  in  1  the detector consumed a serial bit this cycle
- det  in  1  detector match output (Mealy, combinational), sampled on the same edge as its bit
- rd_en  in  1  pop the FIFO head this edge
- rd_data  out  IDX_W  FIFO head (bit index of the oldest logged match); 0 when empty
- rd_valid  out  1  FIFO non-empty
- full  out  1  FIFO holds DEPTH entries
- match_cnt  out  CNT_W  total matches seen since reset, saturating at 2^CNT_W−1
- overflow  out  1  sticky: a match was dropped because the FIFO was full
- bit_idx  out  IDX_W  index the next qualified bit will receive

## Operation
- Reset: bit_idx=0, match_cnt=0, overflow=0, FIFO empty (rd_valid=0, full=0, rd_data=0). Reset wins over every other input on the same edge. A mid-operation reset discards all entries and counts.
- Bit index: on bit_en=1, bit_idx ← bit_idx+1 mod 2^IDX_W. Wrap-around is silent. Without bit_en it holds.
- Match qualification: match = bit_en & det. det without bit_en is ignored.
- On match:
  - Push the pre-increment bit_idx, i.e. the index of the bit that completed the sequence.
  - match_cnt ← match_cnt+1 unless already all-ones, in which case it holds.
- FIFO: circular buffer with wr/rd pointers and an occupancy count (0..DEPTH). rd_data shows the head combinationally from the registered storage and pointer.
- Pop: on rd_en & rd_valid, advance the head. rd_en while empty is a no-op, with no underflow and no state change.
- Push while full and no pop: the entry is dropped and overflow ← 1. match_cnt still increments.
- Push while full with pop on the same edge: both happen, occupancy stays DEPTH, and overflow is unchanged.
- Push while empty with rd_en on the same edge: the pop is ignored and the entry is stored.
- overflow clears only on rst.

## Timing
- All outputs are registered or derived from registers. No combinational path exists from inputs to outputs.
- Latency: a match on edge N appears in rd_valid/rd_data, match_cnt and bit_idx after edge N.
- Pop on edge N: the next entry appears on rd_data after edge N.
- Sustained throughput is one push and one pop per cycle.
- Ordering is strictly FIFO.

## Test plan
- Reset, then hold rst=1 for 2 cycles with bit_en=det=1 → all outputs 0 throughout and after release.
- bit_en=1 for 12 cycles with det=1 only on bits 4 and 10 (stream 1,1,0,1,1,0,0,1,0,1,1,0) → bit_idx=12, match_cnt=2. Successive pops return rd_data=4 then 10, then rd_valid=0.
- With no reads, 6 matches at indices 0..5 (DEPTH=4) → full=1, overflow=1, match_cnt=6. Pops return 0,1,2,3.
- FIFO full with match plus rd_en on the same edge → occupancy stays 4, head advances, the new index lands at the tail, and overflow stays 0.
- 256 bit_en cycles with det=1 on index 255, then one more with det=1 → entries 255 then 0 (wrap), and match_cnt saturates at 255 after 256+ matches with no wrap.
- Reset asserted with 3 entries pending and overflow=1 → next cycle rd_valid=0, overflow=0, match_cnt=0, bit_idx=0. The next match logs index 0.
